// File: rtl/uart_tx_if.sv
// Byte-in / serial-out handshake bundle for uart_tx.
// The master drives the request and byte; the slave (uart_tx) drives the line and status.
interface uart_tx_if;
  logic       tx_start;
  logic [7:0] tx_d_in;
  logic       tx_d_out;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_start,
    output tx_d_in,
    input  tx_d_out,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  tx_d_in,
    output tx_d_out,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// 8-bit UART transmitter: start bit, 8 data bits LSB first, optional even parity, one stop bit.
// Optional feature: define UART_TX_PARITY_EN to insert an even parity bit between data and stop.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic      system_clock,
  input  logic      reset_n,
  uart_tx_if.slave  bus
);

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q,   cnt_d;
  logic [2:0]  idx_q,   idx_d;
  logic [7:0]  data_q,  data_d;
  logic        tx_q,    tx_d;
  logic        busy_q,  busy_d;
  logic        done_q,  done_d;

  logic        bit_end;
  logic [2:0]  idx_nxt;

  assign bit_end = (cnt_q == LAST_CNT);
  assign idx_nxt = idx_q + 3'd1;

  // Every output is a flop; tx_d carries the level the line takes on the next edge.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case can infer a latch.
    state_d = state_q;
    cnt_d   = bit_end ? 16'd0 : cnt_q + 16'd1;
    idx_d   = idx_q;
    data_d  = data_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (bus.tx_start) begin
          state_d = ST_START;
          data_d  = bus.tx_d_in;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
          tx_d    = data_q[0];
        end
      end

      ST_DATA: begin
        if (bit_end) begin
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = ^data_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d = idx_nxt;
            tx_d  = data_q[idx_nxt];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
`endif

      ST_STOP: begin
        // Completion is flagged as the state returns to idle, so a request in the
        // done cycle is already seen by ST_IDLE and the next frame follows directly.
        if (bit_end) begin
          state_d = ST_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge system_clock) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      // NOTE: the byte register is reset as well so an aborted frame leaves no stale data.
      data_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx_d_out = tx_q;
  assign bus.tx_busy  = busy_q;
  assign bus.tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx at CLKS_PER_BIT=4: a scoreboard of expected bytes is
// filled when a request is driven and drained as frames are captured from the serial line.
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC  = FRAME_BITS * CPB;
  localparam int WAIT_LIMIT = 20;

  logic clk;
  logic rst_n;

  uart_tx_if bus ();

  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .system_clock (clk),
    .reset_n      (rst_n),
    .bus          (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];

  // Reference line pattern: start 0, data LSB first, optional even parity, stop 1.
  function automatic logic [10:0] exp_line(input logic [7:0] b);
    logic [10:0] l;
    l      = '1;
    l[0]   = 1'b0;
    l[8:1] = b;
`ifdef UART_TX_PARITY_EN
    l[9]   = ^b;
`endif
    return l;
  endfunction

  // Observe one frame from the line and pop the byte it should carry.
  // The first negedge with tx_busy high is taken as the first start-bit cycle.
  task automatic capture_frame(output bit found, output int wait_n, output logic [10:0] bits,
                               output logic [10:0] expect_bits, output bit stable,
                               output bit busy_ok, output bit done_ok);
    found = 1'b0; wait_n = 0; bits = '1; stable = 1'b1; busy_ok = 1'b1; done_ok = 1'b0;
    expect_bits = 11'h000;
    if (exp_q.size() != 0) expect_bits = exp_line(exp_q.pop_front());
    for (int t = 0; t < WAIT_LIMIT; t++) begin
      @(negedge clk);
      wait_n++;
      if (bus.tx_busy === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) return;
    for (int i = 0; i < FRAME_CYC; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.tx_busy !== 1'b1 || bus.tx_done !== 1'b0) busy_ok = 1'b0;
      if (i % CPB == 0) bits[i / CPB] = bus.tx_d_out;
      else if (bus.tx_d_out !== bits[i / CPB]) stable = 1'b0;
    end
    @(negedge clk);
    done_ok = (bus.tx_busy === 1'b0) && (bus.tx_done === 1'b1);
  endtask

  task automatic test_reset();
    bit found, stable, busy_ok, done_ok;
    int wait_n;
    logic [10:0] bits, expect_bits;
    rst_n = 1'b0;
    bus.tx_start = 1'b1;
    bus.tx_d_in  = 8'h5A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_assert++;
    if (bus.tx_d_out !== 1'b1) begin n_fail++; $display("FAIL reset_line: got %b want 1", bus.tx_d_out); end
    n_assert++;
    if (bus.tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.tx_busy); end
    n_assert++;
    if (bus.tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.tx_done); end
    // Release with tx_start still high: the first un-reset edge must accept it.
    @(posedge clk); #1 rst_n = 1'b1;
    exp_q.push_back(8'h5A);
    @(posedge clk); #1 bus.tx_start = 1'b0;
    capture_frame(found, wait_n, bits, expect_bits, stable, busy_ok, done_ok);
    n_assert++;
    if (!found || wait_n != 1) begin n_fail++; $display("FAIL reset_first_accept: found=%0d wait=%0d want 1/1", found, wait_n); end
    n_assert++;
    if (bits !== expect_bits) begin n_fail++; $display("FAIL reset_first_frame: got %b want %b", bits, expect_bits); end
    n_assert++;
    if (!done_ok) begin n_fail++; $display("FAIL reset_first_done: got busy=%b done=%b want 0/1", bus.tx_busy, bus.tx_done); end
  endtask

  task automatic test_patterns();
    logic [7:0] pats[4] = '{8'h55, 8'h07, 8'hFF, 8'h80};
    bit found, stable, busy_ok, done_ok;
    int wait_n;
    logic [10:0] bits, expect_bits;
    foreach (pats[k]) begin
      bus.tx_d_in  = pats[k];
      bus.tx_start = 1'b1;
      exp_q.push_back(pats[k]);
      @(posedge clk); #1 bus.tx_start = 1'b0;
      capture_frame(found, wait_n, bits, expect_bits, stable, busy_ok, done_ok);
      n_assert++;
      if (!found || wait_n != 1) begin n_fail++; $display("FAIL pat_%h_start: found=%0d wait=%0d want 1/1", pats[k], found, wait_n); end
      n_assert++;
      if (bits !== expect_bits) begin n_fail++; $display("FAIL pat_%h_bits: got %b want %b", pats[k], bits, expect_bits); end
      n_assert++;
      if (!stable) begin n_fail++; $display("FAIL pat_%h_bit_width: line changed inside a %0d-cycle bit", pats[k], CPB); end
      n_assert++;
      if (!busy_ok) begin n_fail++; $display("FAIL pat_%h_busy: busy not high for %0d cycles", pats[k], FRAME_CYC); end
      n_assert++;
      if (!done_ok) begin n_fail++; $display("FAIL pat_%h_done: got busy=%b done=%b want 0/1 at cycle %0d", pats[k], bus.tx_busy, bus.tx_done, FRAME_CYC + 1); end
      @(negedge clk);
      n_assert++;
      if (bus.tx_done !== 1'b0) begin n_fail++; $display("FAIL pat_%h_done_width: got %b want 0", pats[k], bus.tx_done); end
    end
  endtask

  task automatic test_back_to_back();
    bit f1, s1, b1, d1, f2, s2, b2, d2;
    int w1, w2;
    bit idle_ok;
    logic [10:0] bits1, e1, bits2, e2;
    bus.tx_d_in  = 8'hA3;
    bus.tx_start = 1'b1;
    exp_q.push_back(8'hA3);
    fork
      capture_frame(f1, w1, bits1, e1, s1, b1, d1);
      begin
        @(posedge clk); #1 bus.tx_d_in = 8'h3C;
        exp_q.push_back(8'h3C);
        for (int t = 0; t < FRAME_CYC + WAIT_LIMIT; t++) begin
          @(negedge clk);
          if (bus.tx_done === 1'b1) break;
        end
        @(posedge clk); #1 bus.tx_start = 1'b0;
      end
    join
    capture_frame(f2, w2, bits2, e2, s2, b2, d2);
    n_assert++;
    if (bits1 !== e1 || !s1 || !b1 || !d1) begin n_fail++; $display("FAIL b2b_first: got %b want %b stable=%0d busy=%0d done=%0d", bits1, e1, s1, b1, d1); end
    n_assert++;
    if (!f2 || w2 != 1) begin n_fail++; $display("FAIL b2b_gap: second start after %0d cycles want 1", w2); end
    n_assert++;
    if (bits2 !== e2 || !s2 || !b2 || !d2) begin n_fail++; $display("FAIL b2b_second: got %b want %b stable=%0d busy=%0d done=%0d", bits2, e2, s2, b2, d2); end
    idle_ok = 1'b1;
    repeat (2 * CPB) begin
      @(negedge clk);
      if (bus.tx_busy !== 1'b0 || bus.tx_d_out !== 1'b1) idle_ok = 1'b0;
    end
    n_assert++;
    if (!idle_ok) begin n_fail++; $display("FAIL b2b_no_third: busy=%b line=%b want idle", bus.tx_busy, bus.tx_d_out); end
  endtask

  task automatic test_ignore_busy();
    bit found, stable, busy_ok, done_ok, idle_ok;
    int wait_n;
    logic [10:0] bits, expect_bits;
    bus.tx_d_in  = 8'h12;
    bus.tx_start = 1'b1;
    exp_q.push_back(8'h12);
    @(posedge clk); #1 bus.tx_start = 1'b0;
    fork
      capture_frame(found, wait_n, bits, expect_bits, stable, busy_ok, done_ok);
      begin
        repeat (15) @(posedge clk);
        #1 bus.tx_d_in = 8'hFF;
        bus.tx_start = 1'b1;
        @(posedge clk); #1 bus.tx_start = 1'b0;
      end
    join
    n_assert++;
    if (bits !== expect_bits) begin n_fail++; $display("FAIL ignore_byte: got %b want %b", bits, expect_bits); end
    n_assert++;
    if (!busy_ok || !done_ok) begin n_fail++; $display("FAIL ignore_timing: busy=%0d done=%0d want 1/1", busy_ok, done_ok); end
    idle_ok = 1'b1;
    repeat (3 * CPB) begin
      @(negedge clk);
      if (bus.tx_busy !== 1'b0) idle_ok = 1'b0;
    end
    n_assert++;
    if (!idle_ok) begin n_fail++; $display("FAIL ignore_no_second_frame: busy=%b want 0", bus.tx_busy); end
  endtask

  task automatic test_reset_mid_frame();
    bit found, stable, busy_ok, done_ok, quiet_ok;
    int wait_n;
    logic [10:0] bits, expect_bits;
    bus.tx_d_in  = 8'h00;
    bus.tx_start = 1'b1;
    @(posedge clk); #1 bus.tx_start = 1'b0;
    // Cycle 18 of the frame lies inside data bit 3 (cycles 17..20).
    repeat (17) @(posedge clk);
    #1;
    n_assert++;
    if (bus.tx_busy !== 1'b1 || bus.tx_d_out !== 1'b0) begin n_fail++; $display("FAIL abort_pre: busy=%b line=%b want 1/0", bus.tx_busy, bus.tx_d_out); end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_assert++;
    if (bus.tx_d_out !== 1'b1) begin n_fail++; $display("FAIL abort_line: got %b want 1", bus.tx_d_out); end
    n_assert++;
    if (bus.tx_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", bus.tx_busy); end
    @(posedge clk); #1 rst_n = 1'b1;
    quiet_ok = 1'b1;
    repeat (FRAME_CYC + 4) begin
      @(negedge clk);
      if (bus.tx_done !== 1'b0 || bus.tx_busy !== 1'b0) quiet_ok = 1'b0;
    end
    n_assert++;
    if (!quiet_ok) begin n_fail++; $display("FAIL abort_no_done: done=%b busy=%b want 0/0", bus.tx_done, bus.tx_busy); end
    bus.tx_d_in  = 8'hC3;
    bus.tx_start = 1'b1;
    exp_q.push_back(8'hC3);
    @(posedge clk); #1 bus.tx_start = 1'b0;
    capture_frame(found, wait_n, bits, expect_bits, stable, busy_ok, done_ok);
    n_assert++;
    if (!found || bits !== expect_bits || !stable || !busy_ok || !done_ok) begin
      n_fail++;
      $display("FAIL abort_recovery: got %b want %b found=%0d stable=%0d busy=%0d done=%0d", bits, expect_bits, found, stable, busy_ok, done_ok);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.tx_start = 1'b0;
    bus.tx_d_in  = 8'h00;
    rst_n        = 1'b0;
    test_reset();
    test_patterns();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_frame();
    n_assert++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 5208, meaning system_clock cycles per serial bit (9600 baud at 50 MHz); legal range 2..65535.
REQ-002 The block SHALL have port system_clock, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: the reset, which is synchronous and active-low.
REQ-004 The block SHALL have port tx_start, input, 1 bit: request to transmit tx_d_in, sampled each cycle.
REQ-005 The block SHALL have port tx_d_in, input, 8 bits: the data byte, captured on the accepted tx_start.
REQ-006 The block SHALL have port tx_d_out, output, 1 bit: the serial line, idle high.
REQ-007 The block SHALL have port tx_busy, output, 1 bit: high while a frame is in progress.
REQ-008 The block SHALL have port tx_done, output, 1 bit: a one-cycle pulse at frame completion.

Function
REQ-009 The FSM SHALL have the states IDLE, START, DATA, PARITY (when configured per REQ-022) and STOP.
REQ-010 In IDLE with tx_start=1 at edge N, the block SHALL latch tx_d_in, enter START, and drive tx_d_out=0 and tx_busy=1 from edge N+1.
REQ-011 tx_start while tx_busy=1 SHALL be ignored; tx_d_in changes after acceptance SHALL NOT affect the frame.
REQ-012 Each bit (start, data, parity, stop) SHALL hold tx_d_out stable for exactly CLKS_PER_BIT cycles, timed by a 16-bit counter that counts 0..CLKS_PER_BIT-1 and clears at each bit boundary.
REQ-013 DATA SHALL send the 8 latched bits LSB first, using a 3-bit index that advances at each bit boundary; the block SHALL leave DATA after index 7.
REQ-014 STOP SHALL drive tx_d_out=1 for CLKS_PER_BIT cycles, then return to IDLE.
REQ-015 On the cycle after the last STOP cycle, tx_busy SHALL be 0 and tx_done SHALL be 1 for exactly one cycle.
REQ-016 tx_start asserted in that tx_done cycle SHALL be accepted, giving back-to-back frames with no extra idle bit.
REQ-017 Frame length from the first start-bit cycle to the last stop-bit cycle SHALL be 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT when parity is configured in.
REQ-018 tx_d_out SHALL be driven directly from a register (glitch-free).

Reset
REQ-019 With reset_n=0 at a rising edge, the next state SHALL be: state IDLE, tx_d_out=1, tx_busy=0, tx_done=0, counter=0, bit index=0, latched byte=0x00.
REQ-020 Reset mid-frame SHALL abort the frame immediately, with no tx_done pulse; line high from the next edge.
REQ-021 tx_start during reset SHALL be ignored; the first acceptance is possible on the first edge with reset_n=1.

Configuration
REQ-022 When macro UART_TX_PARITY_EN is defined, a PARITY state SHALL follow DATA and send the even parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles before STOP.
REQ-023 When UART_TX_PARITY_EN is undefined, DATA SHALL go directly to STOP, and no parity logic SHALL be synthesized.

Verification (CLKS_PER_BIT=4)
REQ-024 Reset released, tx_start pulse with 0x55 -> line, per 4-cycle bit: 0,1,0,1,0,1,0,1,0,1; tx_busy high for 40 cycles; tx_done pulse at cycle 41.
REQ-025 With UART_TX_PARITY_EN: 0x07 -> bits 0,1,1,1,0,0,0,0,0, parity 1, stop 1 (44 cycles); 0x55 -> parity 0.
REQ-026 tx_start held high continuously with 0xA3 then 0x3C -> two contiguous frames; second start bit begins on the cycle after the first tx_done; no idle gap.
REQ-027 tx_start pulsed and tx_d_in changed to 0xFF mid-frame of 0x12 -> transmitted byte is 0x12; the extra pulse produces no second frame.
REQ-028 reset_n=0 during data bit 3 of 0x00 -> next edge tx_d_out=1, tx_busy=0, tx_done never pulses; a new tx_start after release produces a full correct frame.
